// File: rtl/mem_stream_merger.sv
// Drains up to NBANK memory blocks in encoder-selected order into one bank-tagged valid/ready stream.
// Optional macro MERGE_TRUNC_EN adds a per-event read limit (MAX_OUT) and a truncated flag.
module mem_stream_merger #(
    parameter int NBANK      = 12,
    parameter int NBITS      = 6,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int SEL_WAIT   = 3
`ifdef MERGE_TRUNC_EN
    , parameter int MAX_OUT  = 100
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NBANK*NBITS-1:0]  nentries,
    output logic [NBANK-1:0]        has_dat,
    input  logic [3:0]              sel,
    input  logic                    done,
    output logic                    rd_en,
    output logic [3:0]              rd_bank,
    output logic [NBITS-1:0]        rd_addr,
    input  logic [DATA_W-1:0]       rd_data,
    output logic [DATA_W+3:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic [2:0]              state_dbg,
    output logic                    evt_done
`ifdef MERGE_TRUNC_EN
    , output logic                  truncated
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_LATCH = 3'd2,
        S_READ  = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1);

    state_t            state, state_nx;
    logic [NBITS-1:0]  cnt [NBANK];
    logic [3:0]        bank;
    logic [3:0]        wait_cnt;
    logic [RD_LAT-1:0] tag_v;
    logic [3:0]        tag_b [RD_LAT];

    logic [DATA_W+3:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       fifo_cnt;

    logic              push, pop;
    logic [CW-1:0]     inflight;
    logic              credit_ok;
    logic [15:0]       has_pad;
    logic [3:0]        sel_idx;
    logic              sel_hit;
    logic              last_rd;
    logic              trunc_hit;
    logic              bank_ld, clr_all, drain_done;

    assign state_dbg = state;
    assign rd_bank   = bank;

    // Stream handshake: a word transfers on any cycle with out_valid & out_ready;
    // out_valid never drops and out_data never changes until that happens.
    assign out_valid = (fifo_cnt != '0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    assign pop       = out_valid & out_ready;
    assign push      = tag_v[RD_LAT-1];

    always_comb begin
        inflight = '0;
        for (int k = 0; k < RD_LAT; k++) inflight = inflight + CW'(tag_v[k]);
    end

    // Landing words are still counted as in flight, so a read is only issued
    // when a FIFO slot is guaranteed to be free when its data arrives.
    assign credit_ok = (CW'(fifo_cnt) + inflight) < CW'(FIFO_DEPTH);

    // Padding makes sel=0 (wraps to 15) and sel>NBANK land on a zero bit.
    assign has_pad = 16'(has_dat);
    assign sel_idx = sel - 4'd1;
    assign sel_hit = has_pad[sel_idx];
    assign last_rd = (rd_addr == (cnt[bank] - NBITS'(1)));

`ifdef MERGE_TRUNC_EN
    logic [15:0] issued;
    logic        trunc_pend;

    assign trunc_hit = (issued == 16'(MAX_OUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issued     <= '0;
            trunc_pend <= 1'b0;
            truncated  <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                issued     <= '0;
                trunc_pend <= 1'b0;
                truncated  <= 1'b0;
            end else if (rd_en) begin
                issued <= issued + 16'd1;
            end
            if (state == S_READ && trunc_hit) trunc_pend <= 1'b1;
            if (drain_done) truncated <= trunc_pend;
        end
    end
`else
    assign trunc_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        rd_en      = 1'b0;
        bank_ld    = 1'b0;
        clr_all    = 1'b0;
        drain_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == '0) state_nx = S_LATCH;
            end
            S_LATCH: begin
                if (done) begin
                    state_nx = S_FLUSH;
                end else if (sel_hit) begin
                    bank_ld  = 1'b1;
                    state_nx = S_READ;
                end else begin
                    clr_all  = 1'b1;
                    state_nx = S_FLUSH;
                end
            end
            S_READ: begin
                if (trunc_hit) begin
                    clr_all  = 1'b1;
                    state_nx = S_FLUSH;
                end else if (credit_ok) begin
                    rd_en = 1'b1;
                    if (last_rd) state_nx = S_WAIT;
                end
            end
            S_FLUSH: begin
                if (fifo_cnt == '0 && inflight == '0) begin
                    drain_done = 1'b1;
                    state_nx   = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            has_dat  <= '0;
            bank     <= '0;
            rd_addr  <= '0;
            wait_cnt <= '0;
            busy     <= 1'b0;
            evt_done <= 1'b0;
            for (int i = 0; i < NBANK; i++) cnt[i] <= '0;
        end else begin
            evt_done <= drain_done;
            if (drain_done) busy <= 1'b0;
            if (state == S_IDLE && start) begin
                busy <= 1'b1;
                for (int i = 0; i < NBANK; i++) begin
                    cnt[i]     <= nentries[i*NBITS +: NBITS];
                    has_dat[i] <= (nentries[i*NBITS +: NBITS] != '0);
                end
            end
            // The wait counter reloads on every entry so sel/done always reflect the latest has_dat.
            if (state_nx == S_WAIT && state != S_WAIT)
                wait_cnt <= 4'(SEL_WAIT - 1);
            else if (state == S_WAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - 4'd1;
            if (bank_ld) begin
                bank    <= sel_idx;
                rd_addr <= '0;
            end
            if (rd_en) begin
                rd_addr <= rd_addr + NBITS'(1);
                if (last_rd) has_dat[bank] <= 1'b0;
            end
            if (clr_all) has_dat <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v <= '0;
            for (int k = 0; k < RD_LAT; k++) tag_b[k] <= '0;
        end else begin
            tag_v[0] <= rd_en;
            tag_b[0] <= bank;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_v[k] <= tag_v[k-1];
                tag_b[k] <= tag_b[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {tag_b[RD_LAT-1], rd_data};
    end

endmodule

// File: tb/tb_mem_stream_merger.sv
// Bench for mem_stream_merger: encoder and memory models, queue-based expected stream, directed and random events.
module tb_mem_stream_merger;
    localparam int NBANK      = 12;
    localparam int NBITS      = 6;
    localparam int DATA_W     = 32;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int SEL_WAIT   = 3;
`ifdef MERGE_TRUNC_EN
    localparam int MAX_OUT    = 100;
`else
    localparam int MAX_OUT    = 100000;
`endif

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic [NBANK*NBITS-1:0] nentries;
    logic [NBANK-1:0]       has_dat;
    logic [3:0]             sel;
    logic                   done;
    logic                   rd_en;
    logic [3:0]             rd_bank;
    logic [NBITS-1:0]       rd_addr;
    logic [DATA_W-1:0]      rd_data;
    logic [DATA_W+3:0]      out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic [2:0]             state_dbg;
    logic                   evt_done;
`ifdef MERGE_TRUNC_EN
    logic                   truncated;
`endif

    mem_stream_merger #(
        .NBANK(NBANK), .NBITS(NBITS), .DATA_W(DATA_W),
        .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH), .SEL_WAIT(SEL_WAIT)
`ifdef MERGE_TRUNC_EN
        , .MAX_OUT(MAX_OUT)
`endif
    ) dut (
        .clk(clk), .reset(reset), .start(start), .nentries(nentries),
        .has_dat(has_dat), .sel(sel), .done(done), .rd_en(rd_en),
        .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .state_dbg(state_dbg), .evt_done(evt_done)
`ifdef MERGE_TRUNC_EN
        , .truncated(truncated)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // 2-stage registered priority encoder: lowest set bit wins, sel = index + 1
    logic [3:0] e_sel;
    logic       e_done;
    function automatic logic [3:0] prio(input logic [NBANK-1:0] h);
        logic [3:0] r;
        r = 4'd0;
        for (int i = NBANK - 1; i >= 0; i--) if (h[i]) r = 4'(i + 1);
        return r;
    endfunction
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e_sel <= '0; e_done <= 1'b0; sel <= '0; done <= 1'b0;
        end else begin
            e_sel <= prio(has_dat); e_done <= (has_dat == '0);
            sel <= e_sel; done <= e_done;
        end
    end

    // memory with RD_LAT cycle read latency
    logic [DATA_W-1:0] mem [NBANK][64];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= rd_en ? mem[rd_bank][rd_addr] : 32'hDEAD_BEEF;
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign rd_data = rd_pipe[RD_LAT-1];

    // scoreboard
    logic [DATA_W+3:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cnt_cfg [NBANK];
    bit exp_trunc;
    int rd_cnt = 0, done_cnt = 0, done_cyc = 0;
    int rd_base, done_base, start_cyc;
    int max_addr2;
    logic [NBANK-1:0] has_or;
    bit prev_stall, fall_pend;
    logic [DATA_W+3:0] prev_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            fall_pend  = 1'b0;
        end else begin
            if (rd_en) begin
                rd_cnt++;
                if (rd_bank == 4'd2 && int'(rd_addr) > max_addr2) max_addr2 = int'(rd_addr);
            end
            has_or |= has_dat;
            if (fall_pend) begin
                check("has_dat2_fall", 64'(has_dat[2]), 64'd0);
                fall_pend = 1'b0;
            end
            if (rd_en && rd_bank == 4'd2 && rd_addr == 6'd62) begin
                check("has_dat2_before_last", 64'(has_dat[2]), 64'd1);
                fall_pend = 1'b1;
            end
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'(out_data), 64'(prev_data));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin
                check("word_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("out_word", 64'(out_data), 64'(exp_q.pop_front()));
            end
            if (evt_done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", 64'(busy), 64'd0);
`ifdef MERGE_TRUNC_EN
                check("truncated", 64'(truncated), 64'(exp_trunc));
`endif
            end
        end
    end

    // driver tasks
    task automatic clear_cfg();
        for (int b = 0; b < NBANK; b++) cnt_cfg[b] = 0;
    endtask

    task automatic launch();
        int total;
        total = 0;
        for (int b = 0; b < NBANK; b++) begin
            nentries[b*NBITS +: NBITS] = NBITS'(cnt_cfg[b]);
            for (int a = 0; a < cnt_cfg[b]; a++) begin
                mem[b][a] = $urandom;
                if (total < MAX_OUT) exp_q.push_back({4'(b), mem[b][a]});
                total++;
            end
        end
        exp_trunc = (total > MAX_OUT);
        has_or    = '0;
        max_addr2 = -1;
        rd_base   = rd_cnt;
        done_base = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_evt(input bit rand_ready, input int budget);
        int n;
        n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        check("evt_done_seen", 64'(done_cnt != done_base), 64'd1);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("evt_done_once", 64'(done_cnt - done_base), 64'd1);
        check("words_left", 64'(exp_q.size()), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b1; nentries = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_has_dat", 64'(has_dat), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_rd_bank", 64'(rd_bank), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_evt_done", 64'(evt_done), 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // two banks, free-flowing output
        clear_cfg(); cnt_cfg[0] = 3; cnt_cfg[5] = 2;
        launch();
        check("busy_after_start", 64'(busy), 64'd1);
        wait_evt(1'b0, 200);
        check("t1_reads", 64'(rd_cnt - rd_base), 64'd5);

        // empty event: fixed latency, no reads
        clear_cfg();
        launch();
        wait_evt(1'b0, 50);
        check("empty_reads", 64'(rd_cnt - rd_base), 64'd0);
        check("empty_latency", 64'(done_cyc - start_cyc), 64'(3 + SEL_WAIT));
        check("empty_has_dat", 64'(has_or), 64'd0);

        // stalled output fills the FIFO and stops issuing
        clear_cfg(); cnt_cfg[11] = 8;
        out_ready = 1'b0;
        launch();
        repeat (19) @(posedge clk);
        #1;
        check("stall_reads", 64'(rd_cnt - rd_base), 64'(FIFO_DEPTH));
        check("stall_head_valid", 64'(out_valid), 64'd1);
        check("stall_head_word", 64'(out_data), 64'(exp_q[0]));
        out_ready = 1'b1;
        wait_evt(1'b0, 200);

        // full-size block, random backpressure
        clear_cfg(); cnt_cfg[2] = 63;
        launch();
        wait_evt(1'b1, 2000);
        check("max_addr_bank2", 64'(max_addr2), 64'd62);
        check("reads_bank2", 64'(rd_cnt - rd_base), 64'd63);

        // reset in the middle of reading block 4
        clear_cfg(); cnt_cfg[4] = 20;
        out_ready = 1'b0;
        launch();
        begin
            int n;
            n = 0;
            while (!(rd_en && rd_bank == 4'd4) && n < 100) begin
                @(posedge clk); #1; n++;
            end
        end
        check("reached_bank4", 64'(rd_en && rd_bank == 4'd4), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_has_dat", 64'(has_dat), 64'd0);
        check("mid_rst_rd_en", 64'(rd_en), 64'd0);
        check("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
        check("mid_rst_rd_bank", 64'(rd_bank), 64'd0);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_data", 64'(out_data), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_evt_done", 64'(evt_done), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        repeat (10) @(posedge clk);
        #1;
        check("no_done_after_rst", 64'(done_cnt - done_base), 64'd0);
        clear_cfg(); cnt_cfg[4] = 5; cnt_cfg[7] = 3;
        launch();
        wait_evt(1'b0, 200);

        // random events with random backpressure
        for (int e = 0; e < 4; e++) begin
            clear_cfg();
            for (int b = 0; b < NBANK; b++)
                cnt_cfg[b] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 10)) : 0;
            launch();
            wait_evt(1'b1, 3000);
        end

        // large event: exceeds the read limit when the limit is built in
        clear_cfg(); cnt_cfg[1] = 60; cnt_cfg[3] = 50;
        launch();
        wait_evt(1'b1, 3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
